// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and defaults for the SPI command/register controller.
package spi_reg_pkg;
    typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, ERR} state_t;
    localparam int CMD_RD_BIT = 7;
    localparam int ADDR_W = 7;
    localparam logic [ADDR_W-1:0] RO_ADDR_D = 7'h7F;
    localparam logic [7:0] IDLE_FILL_D = 8'hA5;
    localparam logic [7:0] ERR_FILL_D = 8'hEE;
endpackage

// File: rtl/spi_reg_ctrl_sync2.sv
// sync2: two-flop synchroniser that resets to 1 (idle level of an active-low select).
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or posedge reset)
        if (reset) {q, meta} <= 2'b11;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: per-frame command decode, auto-incrementing register bank
// access and transmit-byte sourcing for a byte-level SPI slave.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int NREG = 16,
    parameter logic [ADDR_W-1:0] RO_ADDR = RO_ADDR_D,
    parameter logic [7:0] IDLE_FILL = IDLE_FILL_D,
    parameter logic [7:0] ERR_FILL = ERR_FILL_D
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ss_n,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [7:0]        tx_byte,
    input  logic [7:0]        ro_status,
    input  logic              err_clr,
    output logic [NREG*8-1:0] regs_o,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              err
);
    localparam int IW = NREG > 1 ? $clog2(NREG) : 1;
    localparam logic [ADDR_W:0] NREG_P = (ADDR_W+1)'(NREG);
    localparam logic [ADDR_W:0] RO_P = {1'b0, RO_ADDR};
    logic ss_s, ss_q, frame_start, frame_end, err_set, wr_en, is_rd;
    state_t state, state_n;
    logic [7:0] tx_n;
    logic [7:0] regs [NREG];
    // one extra bit so an increment past the top address lands out of range instead of wrapping
    logic [ADDR_W:0] ptr, ptr_n, addr;
    sync2 u_sync (.clk(clk), .reset(reset), .d(ss_n), .q(ss_s));
    always_ff @(posedge clk or posedge reset)
        if (reset) ss_q <= 1'b1;
        else ss_q <= ss_s;
    assign frame_start = ss_q & ~ss_s;
    assign frame_end = ~ss_q & ss_s;
    assign busy = ~ss_s;
    assign addr = {1'b0, rx_byte[ADDR_W-1:0]};
    assign is_rd = rx_byte[CMD_RD_BIT];
    function automatic logic [7:0] rd(input logic [ADDR_W:0] x);
        return x < NREG_P ? regs[x[IW-1:0]] : x == RO_P ? ro_status : ERR_FILL;
    endfunction
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        tx_n = tx_byte;
        ptr_n = ptr;
        err_set = 1'b0;
        wr_en = 1'b0;
        case (state)
            IDLE: state_n = frame_start ? CMD : IDLE;
            CMD:
                if (rx_valid) begin
                    if (!(addr < NREG_P || (addr == RO_P && is_rd))) begin
                        state_n = ERR;
                        tx_n = ERR_FILL;
                        err_set = 1'b1;
                    end else if (is_rd) begin
                        state_n = READ;
                        tx_n = rd(addr);
                        ptr_n = addr + 1'b1;
                    end else begin
                        state_n = WRITE;
                        ptr_n = addr;
                    end
                end
            WRITE:
                if (rx_valid) begin
                    if (ptr < NREG_P) begin
                        wr_en = 1'b1;
                        ptr_n = ptr + 1'b1;
                    end else begin
                        state_n = ERR;
                        tx_n = ERR_FILL;
                        err_set = 1'b1;
                    end
                end
            READ:
                if (rx_valid) begin
                    if (ptr >= NREG_P && ptr != RO_P) begin
                        state_n = ERR;
                        tx_n = ERR_FILL;
                        err_set = 1'b1;
                    end else begin
                        tx_n = rd(ptr);
                        ptr_n = ptr + 1'b1;
                    end
                end
            ERR: state_n = ERR;
            default: state_n = IDLE;
        endcase
        // a byte completing in the same cycle as deselect is handled above, then the frame closes
        if (frame_end) begin
            state_n = IDLE;
            tx_n = IDLE_FILL;
            ptr_n = '0;
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            tx_byte <= IDLE_FILL;
            ptr <= '0;
            err <= 1'b0;
            wr_stb <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            regs <= '{default: 8'h00};
        end else begin
            tx_byte <= tx_n;
            ptr <= ptr_n;
            err <= err_set | (err & ~err_clr);
            wr_stb <= wr_en;
            if (wr_en) begin
                regs[ptr[IW-1:0]] <= rx_byte;
                wr_addr <= ptr[ADDR_W-1:0];
                wr_data <= rx_byte;
            end
        end
    for (genvar i = 0; i < NREG; i++) begin : g_regs
        assign regs_o[8*i +: 8] = regs[i];
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed frames against spi_reg_ctrl with hand-computed expectations.
module tb_spi_reg_ctrl;
    logic clk = 1'b0, reset = 1'b1, ss_n = 1'b1, rx_valid = 1'b0, err_clr = 1'b0;
    logic [7:0] rx_byte = 8'h00, ro_status = 8'h00, tx_byte, wr_data;
    logic [127:0] regs_o;
    logic [6:0] wr_addr;
    logic wr_stb, busy, err;
    int n_checks = 0, n_fail = 0;

    spi_reg_ctrl dut (
        .clk(clk), .reset(reset), .ss_n(ss_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .ro_status(ro_status), .err_clr(err_clr), .regs_o(regs_o),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame_begin();
        @(negedge clk) ss_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_finish();
        @(negedge clk) ss_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return regs_o[8*i +: 8];
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx_byte, 8'hA5);
        check("rst_regs_lo", regs_o[31:0], 0);
        check("rst_regs_hi", regs_o[127:96], 0);
        check("rst_wr_stb", wr_stb, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        frame_begin();
        check("busy_in_frame", busy, 1);
        send(8'h03);
        check("cmd_no_stb", wr_stb, 0);
        send(8'h11);
        check("w1_stb", wr_stb, 1);
        check("w1_addr", wr_addr, 3);
        check("w1_data", wr_data, 8'h11);
        send(8'h22);
        check("w2_stb", wr_stb, 1);
        check("w2_addr", wr_addr, 4);
        check("w2_data", wr_data, 8'h22);
        check("reg3", reg_at(3), 8'h11);
        check("reg4", reg_at(4), 8'h22);
        @(negedge clk);
        check("stb_single", wr_stb, 0);
        frame_finish();
        check("busy_after", busy, 0);
        check("err_after_write", err, 0);

        frame_begin();
        send(8'h83);
        check("rd_tx1", tx_byte, 8'h11);
        send(8'h00);
        check("rd_tx2", tx_byte, 8'h22);
        frame_finish();
        check("rd_tx_idle", tx_byte, 8'hA5);

        ro_status = 8'h5C;
        frame_begin();
        send(8'hFF);
        check("ro_tx", tx_byte, 8'h5C);
        check("ro_err", err, 0);
        frame_finish();
        frame_begin();
        send(8'h7F);
        check("ro_wr_tx", tx_byte, 8'hEE);
        check("ro_wr_err", err, 1);
        send(8'h01);
        check("ro_wr_no_stb", wr_stb, 0);
        check("ro_wr_tx_held", tx_byte, 8'hEE);
        frame_finish();
        check("err_frame_tx_idle", tx_byte, 8'hA5);
        check("err_sticky", err, 1);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        check("err_cleared", err, 0);

        frame_begin();
        send(8'h0F);
        send(8'hAA);
        check("top_stb", wr_stb, 1);
        check("top_addr", wr_addr, 15);
        check("reg15", reg_at(15), 8'hAA);
        send(8'hBB);
        check("over_no_stb", wr_stb, 0);
        check("over_err", err, 1);
        check("over_tx", tx_byte, 8'hEE);
        check("reg15_kept", reg_at(15), 8'hAA);
        frame_finish();

        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        frame_begin();
        send(8'h8F);
        check("rd15_tx", tx_byte, 8'hAA);
        check("rd15_err", err, 0);
        send(8'h00);
        check("rd_over_tx", tx_byte, 8'hEE);
        check("rd_over_err", err, 1);
        frame_finish();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;

        frame_begin();
        send(8'h05);
        ss_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rx_byte = 8'h77;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("end_same_stb", wr_stb, 1);
        check("end_same_addr", wr_addr, 5);
        check("end_same_data", wr_data, 8'h77);
        check("end_same_tx", tx_byte, 8'hA5);
        check("end_same_busy", busy, 0);
        send(8'h44);
        check("idle_ignored_stb", wr_stb, 0);
        check("reg5", reg_at(5), 8'h77);
        check("reg6_untouched", reg_at(6), 0);

        frame_begin();
        send(8'h83);
        check("pre_rst_tx", tx_byte, 8'h11);
        @(negedge clk);
        reset = 1'b1;
        ss_n = 1'b1;
        #1;
        check("mid_rst_tx", tx_byte, 8'hA5);
        check("mid_rst_regs", regs_o[63:32], 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        frame_begin();
        send(8'h02);
        send(8'h99);
        check("post_rst_stb", wr_stb, 1);
        check("post_rst_addr", wr_addr, 2);
        check("post_rst_reg2", reg_at(2), 8'h99);
        frame_finish();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
